// File: rtl/zeroheti_obi_xbar_demux.sv
// Single-master to NumSlaves-slave OBI demultiplexer driven by a packed
// base/last address map. All in-flight transactions are kept on one target
// so responses return in order. Unmapped accesses are answered internally
// with an error response.
module zeroheti_obi_xbar_demux #(
   parameter int unsigned                 NumSlaves      = 7,
   // Index i lives at bits [32i+31:32i], so the lowest index is rightmost.
   parameter logic [NumSlaves*32-1:0]     AddrBase       = {32'h0002_0000, 32'h0000_A000, 32'h0000_5000,
                                                            32'h0000_2100, 32'h0000_2000, 32'h0000_1000,
                                                            32'h0000_0000},
   parameter logic [NumSlaves*32-1:0]     AddrLast       = {32'hFFFF_FFFF, 32'h0001_3000, 32'h0000_A000,
                                                            32'h0000_2114, 32'h0000_2100, 32'h0000_2000,
                                                            32'h0000_1000},
   parameter int unsigned                 MaxOutstanding = 4,
   parameter logic [31:0]                 ErrData        = 32'hBADC_AB1E
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      m_req_i,
   input  logic [31:0]               m_addr_i,
   input  logic                      m_we_i,
   input  logic [3:0]                m_be_i,
   input  logic [31:0]               m_wdata_i,
   output logic                      m_gnt_o,
   output logic                      m_rvalid_o,
   output logic [31:0]               m_rdata_o,
   output logic                      m_err_o,
   output logic [NumSlaves-1:0]      s_req_o,
   output logic [31:0]               s_addr_o,
   output logic                      s_we_o,
   output logic [3:0]                s_be_o,
   output logic [31:0]               s_wdata_o,
   input  logic [NumSlaves-1:0]      s_gnt_i,
   input  logic [NumSlaves-1:0]      s_rvalid_i,
   input  logic [NumSlaves*32-1:0]   s_rdata_i,
   input  logic [NumSlaves-1:0]      s_err_i,
   output logic [3:0]                outstanding_o,
   output logic                      spurious_o
);

   // Handshake: a request is accepted in a cycle where m_req_i and m_gnt_o are
   // both high; every accepted request gets exactly one m_rvalid_o pulse, in
   // acceptance order. Master fields must be held while m_req_i=1 and m_gnt_o=0.

   localparam int unsigned     TgtW   = $clog2(NumSlaves + 1);
   localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumSlaves);
   localparam logic [3:0]      MaxCnt = 4'(MaxOutstanding);

   logic [3:0]           cnt_q, cnt_d;
   logic [TgtW-1:0]      cur_tgt_q, cur_tgt_d;
   logic [3:0]           err_pend_q, err_pend_d;
   logic                 spurious_q, spurious_d;

   logic [TgtW-1:0]      tgt;
   logic                 stall;
   logic                 issue;
   logic [NumSlaves-1:0] s_req;
   logic                 gnt;
   logic                 rvalid;
   logic [31:0]          rdata;
   logic                 rerr;
   logic                 spur_hit;

   // Address decode: lowest matching region wins, no match selects the error target.
   always_comb begin
      tgt = ErrTgt;
      for (int i = int'(NumSlaves) - 1; i >= 0; i--) begin
         if ((m_addr_i >= AddrBase[32*i +: 32]) && (m_addr_i < AddrLast[32*i +: 32])) begin
            tgt = TgtW'(i);
         end
      end
   end

   // Issue gate and forwarding: only one target may hold in-flight transactions.
   always_comb begin
      stall = (cnt_q == MaxCnt) | ((cnt_q != 4'd0) & (tgt != cur_tgt_q));
      issue = m_req_i & ~stall;
      s_req = '0;
      gnt   = 1'b0;
      if (tgt == ErrTgt) begin
         gnt = issue;
      end else begin
         s_req[tgt] = issue;
         gnt        = issue & s_gnt_i[tgt];
      end
   end

   // Response path: internal error responses or the current target's response.
   always_comb begin
      rvalid = 1'b0;
      rdata  = '0;
      rerr   = 1'b0;
      if (cur_tgt_q == ErrTgt) begin
         if (err_pend_q != 4'd0) begin
            rvalid = 1'b1;
            rdata  = ErrData;
            rerr   = 1'b1;
         end
      end else if ((cnt_q != 4'd0) && s_rvalid_i[cur_tgt_q]) begin
         rvalid = 1'b1;
         rdata  = s_rdata_i[32*cur_tgt_q +: 32];
         rerr   = s_err_i[cur_tgt_q];
      end
   end

   // Any slave response that does not belong to an in-flight transaction.
   always_comb begin
      spur_hit = 1'b0;
      for (int j = 0; j < int'(NumSlaves); j++) begin
         if (s_rvalid_i[j] && ((cnt_q == 4'd0) || (TgtW'(j) != cur_tgt_q))) begin
            spur_hit = 1'b1;
         end
      end
   end

   // Next-state: in-flight count, current target, owed error responses, sticky flag.
   always_comb begin
      cnt_d      = cnt_q;
      cur_tgt_d  = cur_tgt_q;
      err_pend_d = err_pend_q;
      spurious_d = spurious_q | spur_hit;
      case ({gnt, rvalid})
         2'b10:   cnt_d = cnt_q + 4'd1;
         2'b01:   cnt_d = cnt_q - 4'd1;
         default: cnt_d = cnt_q;
      endcase
      if (gnt) begin
         cur_tgt_d = tgt;
      end
      case ({gnt & (tgt == ErrTgt), rvalid & (cur_tgt_q == ErrTgt)})
         2'b10:   err_pend_d = err_pend_q + 4'd1;
         2'b01:   err_pend_d = err_pend_q - 4'd1;
         default: err_pend_d = err_pend_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= 4'd0;
         cur_tgt_q  <= '0;
         err_pend_q <= 4'd0;
         spurious_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         cur_tgt_q  <= cur_tgt_d;
         err_pend_q <= err_pend_d;
         spurious_q <= spurious_d;
      end
   end

   // Outputs are forced low while reset is asserted, even though some are combinational.
   assign s_req_o       = s_req & {NumSlaves{rst_ni}};
   assign s_addr_o      = m_addr_i & {32{rst_ni}};
   assign s_we_o        = m_we_i & rst_ni;
   assign s_be_o        = m_be_i & {4{rst_ni}};
   assign s_wdata_o     = m_wdata_i & {32{rst_ni}};
   assign m_gnt_o       = gnt & rst_ni;
   assign m_rvalid_o    = rvalid & rst_ni;
   assign m_rdata_o     = rdata & {32{rst_ni}};
   assign m_err_o       = rerr & rst_ni;
   assign outstanding_o = cnt_q;
   assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_zeroheti_obi_xbar_demux.sv
// Bench for zeroheti_obi_xbar_demux: random master traffic against random
// slave models, expected responses queued at accept time and compared by an
// independent monitor, followed by spurious-response and mid-operation reset
// scenarios.
module tb_zeroheti_obi_xbar_demux;

   localparam int NS   = 7;
   localparam int MAXO = 4;
   localparam logic [31:0] ERR_DATA = 32'hBADC_AB1E;
   localparam logic [31:0] BASE [NS] = '{32'h0, 32'h1000, 32'h2000, 32'h2100, 32'h5000, 32'hA000, 32'h20000};
   localparam logic [31:0] LAST [NS] = '{32'h1000, 32'h2000, 32'h2100, 32'h2114, 32'hA000, 32'h13000, 32'hFFFF_FFFF};
   localparam logic [31:0] ADDR_TAB [14] = '{32'h5004, 32'h2114, 32'h10, 32'h1004, 32'h20F8, 32'h2104, 32'hA100,
                                             32'h12FFC, 32'h13000, 32'h20010, 32'hFFFF_FFFC, 32'hFFFF_FFFF,
                                             32'h4FFC, 32'h0FFC};

   logic              clk;
   logic              rst_n;
   logic              m_req_i;
   logic [31:0]       m_addr_i;
   logic              m_we_i;
   logic [3:0]        m_be_i;
   logic [31:0]       m_wdata_i;
   logic              m_gnt_o;
   logic              m_rvalid_o;
   logic [31:0]       m_rdata_o;
   logic              m_err_o;
   logic [NS-1:0]     s_req_o;
   logic [31:0]       s_addr_o;
   logic              s_we_o;
   logic [3:0]        s_be_o;
   logic [31:0]       s_wdata_o;
   logic [NS-1:0]     s_gnt_i;
   logic [NS-1:0]     s_rvalid_i;
   logic [NS*32-1:0]  s_rdata_i;
   logic [NS-1:0]     s_err_i;
   logic [3:0]        outstanding_o;
   logic              spurious_o;

   zeroheti_obi_xbar_demux dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
      .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
      .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
      .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
      .outstanding_o(outstanding_o), .spurious_o(spurious_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- shared bench state ----------------
   logic [32:0] exp_q [$];          // {err, rdata} in acceptance order
   int          checks   = 0;
   int          failures = 0;
   logic        stim_done   = 1'b0;
   logic        drv_timeout = 1'b0;

   // Reference decode: lowest index whose [base, last) contains the address.
   function automatic int ref_decode(input logic [31:0] a);
      for (int i = 0; i < NS; i++) begin
         if (a >= BASE[i] && a < LAST[i]) return i;
      end
      return NS;
   endfunction

   function automatic logic [31:0] slave_data(input logic [31:0] a, input int j);
      return (a * 32'h9E37_79B1) ^ 32'(j);
   endfunction

   function automatic logic slave_err(input logic [31:0] a);
      return a[3:2] == 2'b11;
   endfunction

   // ---------------- driver: master + slave models ----------------
   logic [31:0] sq_addr [NS][$];
   int          sq_rdy  [NS][$];
   int          last_rdy [NS];
   int          cyc = 0;
   logic        req_pending = 1'b0;
   int          wait_cnt = 0;
   int          run_left = 0;
   logic [31:0] burst_addr = 32'h0;
   logic        no_new = 1'b0;
   logic        hold_resp = 1'b0;
   logic        fixed_en = 1'b0;
   logic [31:0] fixed_addr = 32'h0;

   task automatic drive_slaves();
      logic [31:0] a;
      s_rvalid_i = '0;
      s_rdata_i  = '0;
      s_err_i    = '0;
      for (int j = 0; j < NS; j++) begin
         s_gnt_i[j] = ($urandom_range(0, 3) != 0);
         if (!hold_resp && sq_addr[j].size() > 0 && sq_rdy[j][0] <= cyc) begin
            a = sq_addr[j].pop_front();
            void'(sq_rdy[j].pop_front());
            s_rvalid_i[j]          = 1'b1;
            s_rdata_i[32*j +: 32]  = slave_data(a, j);
            s_err_i[j]             = slave_err(a);
         end
      end
   endtask

   task automatic drive_master();
      logic [31:0] a;
      if (req_pending) begin
         wait_cnt++;
         if (wait_cnt > 200) drv_timeout = 1'b1;
         return;
      end
      if (no_new || $urandom_range(0, 3) == 0) begin
         m_req_i = 1'b0;
         return;
      end
      if (fixed_en) begin
         a = fixed_addr;
      end else begin
         if (run_left == 0) begin
            burst_addr = ADDR_TAB[$urandom_range(0, 13)];
            run_left   = $urandom_range(1, 6);
         end
         run_left--;
         a = burst_addr;
         if ($urandom_range(0, 15) == 0) a = $urandom;
      end
      m_req_i     = 1'b1;
      m_addr_i    = a;
      m_we_i      = 1'($urandom_range(0, 1));
      m_be_i      = 4'($urandom);
      m_wdata_i   = $urandom;
      req_pending = 1'b1;
      wait_cnt    = 0;
   endtask

   task automatic sample();
      int t;
      int rdy;
      if (m_req_i && m_gnt_o) begin
         t = ref_decode(m_addr_i);
         if (t == NS) exp_q.push_back({1'b1, ERR_DATA});
         else         exp_q.push_back({slave_err(m_addr_i), slave_data(m_addr_i, t)});
         req_pending = 1'b0;
      end
      for (int j = 0; j < NS; j++) begin
         if (s_req_o[j] && s_gnt_i[j]) begin
            rdy = cyc + 1 + $urandom_range(0, 4);
            if (last_rdy[j] >= rdy) rdy = last_rdy[j] + 1;
            last_rdy[j] = rdy;
            sq_addr[j].push_back(s_addr_o);
            sq_rdy[j].push_back(rdy);
         end
      end
   endtask

   task automatic one_cycle();
      drive_slaves();
      drive_master();
      @(negedge clk);
      sample();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   function automatic logic slaves_idle();
      for (int j = 0; j < NS; j++) if (sq_addr[j].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      rst_n = 1'b0; m_req_i = 1'b0; m_addr_i = '0; m_we_i = 1'b0; m_be_i = '0; m_wdata_i = '0;
      s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0; s_err_i = '0;
      for (int j = 0; j < NS; j++) last_rdy[j] = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Random traffic.
      for (int k = 0; k < 3000; k++) one_cycle();

      // Drain everything, then a slave responds while idle.
      no_new = 1'b1;
      begin : drain
         for (int k = 0; k < 500; k++) begin
            if (!req_pending && outstanding_o == 4'd0 && slaves_idle()) disable drain;
            one_cycle();
         end
         drv_timeout = 1'b1;
      end
      s_rvalid_i = '0; s_rvalid_i[2] = 1'b1; s_rdata_i = {NS{32'hCAFE_0002}};
      @(posedge clk); #1;
      s_rvalid_i = '0; s_rdata_i = '0;
      repeat (3) begin @(posedge clk); #1; end

      // Build up three in-flight dmem reads with responses withheld, then reset.
      no_new = 1'b0; hold_resp = 1'b1; fixed_en = 1'b1; fixed_addr = 32'h0000_A010;
      begin : fill
         for (int k = 0; k < 200; k++) begin
            if (outstanding_o == 4'd3) disable fill;
            one_cycle();
         end
         drv_timeout = 1'b1;
      end
      m_req_i = 1'b1; m_addr_i = 32'h0000_A000; s_gnt_i = '1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_req_i = 1'b0; req_pending = 1'b0; hold_resp = 1'b0; fixed_en = 1'b0; no_new = 1'b1;
      for (int j = 0; j < NS; j++) begin
         sq_addr[j].delete(); sq_rdy[j].delete(); last_rdy[j] = 0;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Stale dmem response after reset release.
      s_rvalid_i = '0; s_rvalid_i[5] = 1'b1; s_rdata_i = {NS{32'h5757_0005}};
      @(posedge clk); #1;
      s_rvalid_i = '0; s_rdata_i = '0;
      repeat (3) begin @(posedge clk); #1; end
      stim_done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      int            rd_idx;
      int            ref_cnt;
      int            ref_tgt;
      logic          ref_spur;
      int            t;
      logic          exp_stall;
      logic [NS-1:0] exp_sreq;
      logic          exp_gnt;
      logic          exp_rv;
      int            ncyc;
      rd_idx = 0; ref_cnt = 0; ref_tgt = 0; ref_spur = 1'b0; ncyc = 0;
      forever begin
         @(negedge clk or negedge rst_n);
         ncyc++;
         if (!rst_n) begin
            #1;
            chk("reset_outputs",
                {m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o},
                96'h0);
            chk("reset_outstanding", 96'(outstanding_o), 96'h0);
            chk("reset_spurious", 96'(spurious_o), 96'h0);
            ref_cnt = 0; ref_tgt = 0; ref_spur = 1'b0; rd_idx = exp_q.size();
         end else begin
            t         = ref_decode(m_addr_i);
            exp_stall = (ref_cnt == MAXO) || (ref_cnt != 0 && t != ref_tgt);
            exp_sreq  = '0;
            exp_gnt   = 1'b0;
            if (m_req_i && !exp_stall) begin
               if (t == NS) exp_gnt = 1'b1;
               else begin
                  exp_sreq[t] = 1'b1;
                  exp_gnt     = s_gnt_i[t];
               end
            end
            chk("s_req", 96'(s_req_o), 96'(exp_sreq));
            chk("m_gnt", 96'(m_gnt_o), 96'(exp_gnt));
            chk("s_fields", {s_addr_o, s_we_o, s_be_o, s_wdata_o}, {m_addr_i, m_we_i, m_be_i, m_wdata_i});

            if (ref_cnt == 0)       exp_rv = 1'b0;
            else if (ref_tgt == NS) exp_rv = 1'b1;
            else                    exp_rv = s_rvalid_i[ref_tgt];
            chk("m_rvalid", 96'(m_rvalid_o), 96'(exp_rv));
            if (m_rvalid_o) begin
               if (rd_idx < exp_q.size()) begin
                  chk("resp_data", {m_err_o, m_rdata_o}, 96'(exp_q[rd_idx]));
                  rd_idx++;
               end else begin
                  chk("resp_unexpected", 96'(m_rvalid_o), 96'h0);
               end
            end else begin
               chk("idle_resp", {m_err_o, m_rdata_o}, 96'h0);
            end

            chk("outstanding", 96'(outstanding_o), 96'(ref_cnt));
            chk("spurious", 96'(spurious_o), 96'(ref_spur));
            for (int j = 0; j < NS; j++) begin
               if (s_rvalid_i[j] && (ref_cnt == 0 || j != ref_tgt)) ref_spur = 1'b1;
            end
            if (m_req_i && exp_gnt) ref_tgt = t;
            ref_cnt = ref_cnt + int'(m_req_i && exp_gnt) - int'(exp_rv);
         end

         if (stim_done || ncyc > 20000) begin
            chk("global_timeout", 96'(ncyc > 20000), 96'h0);
            chk("driver_timeout", 96'(drv_timeout), 96'h0);
            chk("all_responses", 96'(rd_idx), 96'(exp_q.size()));
            chk("final_spurious", 96'(spurious_o), 96'h1);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

endmodule

// File: doc/zeroheti_obi_xbar_demux.md
Name: zeroheti_obi_xbar_demux

Overview:
- Parametrised single-master to N-slave OBI demultiplexer, driven by a generalised address map.
- Sits between the ibex data port and the peripherals/memories: debug, HET-IC, UART, mtimer, imem, dmem and external.
- Successor to the fixed seven-region map:
  - region count and per-region base/last are parameters;
  - multiple requests may be in flight;
  - responses stay in order;
  - unmapped accesses get a built-in error response.

Parameters:
- NumSlaves, 7, number of address regions/slave ports (1..16).
- AddrBase, {32'h0,32'h1000,32'h2000,32'h2100,32'h5000,32'hA000,32'h20000}, NumSlaves*32-bit packed region base addresses; index i at bits [32i+31:32i].
- AddrLast, {32'h1000,32'h2000,32'h2100,32'h2114,32'hA000,32'h13000,32'hFFFFFFFF}, NumSlaves*32-bit packed exclusive end addresses.
- MaxOutstanding, 4, maximum in-flight granted-but-unanswered transactions (1..15).
- ErrData, 32'hBADCAB1E, rdata returned on decode error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- m_req_i  in  1  master request.
- m_addr_i  in  32  master address.
- m_we_i  in  1  write enable.
- m_be_i  in  4  byte enables.
- m_wdata_i  in  32  write data.
- m_gnt_o  out  1  grant to master.
- m_rvalid_o  out  1  response valid to master.
- m_rdata_o  out  32  response data.
- m_err_o  out  1  response error.
- s_req_o  out  NumSlaves  per-slave request, one-hot or zero.
- s_addr_o, s_we_o, s_be_o, s_wdata_o  out  32/1/4/32  broadcast copies of master fields.
- s_gnt_i  in  NumSlaves  per-slave grant.
- s_rvalid_i  in  NumSlaves  per-slave response valid.
- s_rdata_i  in  NumSlaves*32  per-slave read data.
- s_err_i  in  NumSlaves  per-slave error.
- outstanding_o  out  4  current in-flight count.
- spurious_o  out  1  sticky flag: response arrived with no matching in-flight transaction.

Behaviour:
- Decode (combinational):
  - region i hits when AddrBase[i] <= m_addr_i < AddrLast[i], with 32-bit unsigned compare.
  - Overlapping hits resolve to the lowest index.
  - No hit selects the internal error target (index NumSlaves).
- State registers:
  - cnt, 4-bit in-flight count;
  - cur_tgt, target of the in-flight transactions;
  - err_pend, error responses owed (counter 0..MaxOutstanding);
  - spurious, sticky flag.
- Reset values: cnt=0, cur_tgt=0, err_pend=0, spurious=0.
- Reset output values: all outputs 0, m_rdata_o=0.
- Issue gate: stall = (cnt==MaxOutstanding) | (cnt!=0 & tgt!=cur_tgt). This keeps all in-flight transactions on one target, which guarantees in-order responses.
- Forwarding:
  - s_req_o[tgt] = m_req_i & !stall; all other s_req_o bits are 0.
  - s_req_o is combinational from master inputs: zero added latency.
- Grant:
  - mapped target: m_gnt_o = s_gnt_i[tgt] & s_req_o[tgt].
  - error target: m_gnt_o = m_req_i & !stall, i.e. granted in the same cycle.
- Accept is m_req_i & m_gnt_o. On accept, cur_tgt <= tgt; if tgt is the error target, err_pend increments.
- Response, mapped:
  - m_rvalid_o = s_rvalid_i[cur_tgt] & cnt!=0;
  - rdata/err are muxed from s_rdata_i/s_err_i of cur_tgt.
- Response, error:
  - when cur_tgt is the error target and err_pend!=0, m_rvalid_o=1, m_rdata_o=ErrData, m_err_o=1;
  - err_pend decrements that cycle;
  - first error response is exactly 1 cycle after its grant.
  - Back-to-back error requests give one response per cycle.
- While m_rvalid_o=0, m_rdata_o and m_err_o are 0.
- Counter update: cnt += accept - response.
  - Accept and response in the same cycle leave cnt unchanged.
  - cnt never exceeds MaxOutstanding and never underflows.
- Spurious responses:
  - any s_rvalid_i[j] with j!=cur_tgt, or with cnt==0, sets spurious (sticky until reset);
  - the response is not forwarded and cnt is unaffected.
- m_addr_i/we/be/wdata must be held stable while m_req_i=1 and m_gnt_o=0 (OBI rule); the block does not re-check this.
- Reset mid-operation: all counters clear immediately; responses from slaves after reset release are treated as spurious.
- outstanding_o = cnt.

Test Plan:
- Single read to 0x0000_5004 with slave 4 gnt same cycle and rvalid 1 cycle later, rdata 0x1234_5678 -> s_req_o=7'b0010000; m_rvalid_o one cycle after grant; m_rdata_o=0x12345678; cnt returns to 0.
- Read 0x0000_2114, an unmapped gap -> m_gnt_o in the same cycle; next cycle m_rvalid_o=1, m_err_o=1, m_rdata_o=0xBADCAB1E; no s_req_o bit set.
- Four pipelined reads to dmem with responses delayed -> after 4 grants outstanding_o=4; a fifth request stalls (m_gnt_o=0) until the first rvalid; responses come back in order.
- Read dmem (response pending), then request UART -> UART request held with s_req_o=0 until dmem rvalid returns cnt to 0, then issued.
- Same-cycle accept and rvalid on one target with cnt=2 -> cnt stays 2.
- s_rvalid_i[2] pulsed while idle -> spurious_o=1 and held; m_rvalid_o=0.
- Assert rst_ni low with cnt=3 -> cnt=0, spurious_o=0, all outputs 0 asynchronously.
